jtframe_upld: RTL
=================

Name: jtframe_upld

Overview:
- Read-back counterpart of the ROM download path: streams SDRAM contents out over the ioctl byte interface, for NVRAM/hiscore save and memory dumps.
- Converts byte requests on ioctl into 16-bit SDRAM word reads through the prog_* read handshake.
- Keeps a one-word cache so that the second byte of a word needs no SDRAM access.
- Uses the same address partitioning (header, bank starts, PROM region, byte swap) as the download side, so upload addresses map to the locations the download wrote.

Parameters:
- HEADER, 0: number of leading ioctl bytes that are not stored in SDRAM.
- PROM_START, ~25'd0: part_addr at or above this value is PROM space (all-ones = disabled).
- BA1_START, ~25'd0: part_addr start of bank 1 (all-ones = unused).
- BA2_START, ~25'd0: part_addr start of bank 2 (all-ones = unused).
- BA3_START, ~25'd0: part_addr start of bank 3 (all-ones = unused).
- SWAB, 0: bit 0 inverts the byte-lane selection.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- uploading  in  1  upload session active
- ioctl_addr  in  25  byte address, valid with ioctl_rd
- ioctl_rd  in  1  one-cycle byte request
- ioctl_din  out  8  returned byte
- ioctl_wait  out  1  high while a fetch is pending; ioctl_din is valid when this is low
- prog_addr  out  22  SDRAM word address
- prog_ba  out  2  SDRAM bank
- prog_rd  out  1  SDRAM read request
- sdram_ack  in  1  request accepted
- data_rdy  in  1  data_read valid
- data_read  in  16  SDRAM word

Behaviour:
- Reset values: ioctl_din=0, ioctl_wait=0, prog_rd=0, prog_addr=0, prog_ba=0, cache invalid, state IDLE.
- Address decoding (combinational):
  - part_addr = ioctl_addr-HEADER.
  - hdr = HEADER!=0 && ioctl_addr<HEADER.
  - prom = PROM_START!=all-ones && part_addr>=PROM_START.
  - bank = highest n with BAn_START <= part_addr; bank 0 if no bank starts are defined.
  - eff_addr = part_addr - start of the selected bank.
  - word = eff_addr[22:1].
  - lane select: sel = eff_addr[0]^SWAB[0]; sel=0 returns data_read[15:8], sel=1 returns data_read[7:0].
- States: IDLE, REQ, WAIT.
- IDLE, when ioctl_rd && uploading:
  - hdr: ioctl_din<=8'hFF on the next edge; no SDRAM access.
  - prom: ioctl_din<=8'h00 on the next edge; no SDRAM access.
  - Cache hit (valid, cached bank==bank, cached word==word): ioctl_din<=selected byte of the cached word on the next edge; ioctl_wait stays 0.
  - Miss: on the next edge ioctl_wait<=1, prog_rd<=1, prog_addr<=word, prog_ba<=bank; latch sel; go to REQ.
- REQ: prog_rd stays high until sdram_ack; on sdram_ack, prog_rd<=0 and go to WAIT.
  - If data_rdy arrives in the same cycle as sdram_ack, complete the WAIT actions in that cycle.
- WAIT: on data_rdy, cache<=data_read with tag {bank,word} and valid=1, ioctl_din<=selected byte, ioctl_wait<=0, go to IDLE.
  - Best-case miss latency: request cycle + 1, plus SDRAM latency.
- ioctl_rd while ioctl_wait=1 is ignored; the pending fetch is unaffected.
- ioctl_rd while uploading=0 is ignored.
- uploading falling edge (any state): prog_rd<=0, ioctl_wait<=0, cache invalid, state IDLE.
  - A data_rdy arriving afterwards is dropped.
- uploading rising edge: cache invalid, so a stale word is never served across sessions.
- rst takes priority over everything, in every state.

Test Plan:
- Miss then hit: HEADER=0, no banks. ioctl_rd @0x10 → prog_rd=1, prog_addr=0x8, prog_ba=0; ack, then data_rdy with 0xA55A → ioctl_din=0xA5, wait drops. Then ioctl_rd @0x11 → ioctl_din=0x5A next cycle, no prog_rd.
- Header and PROM: HEADER=0x40, PROM_START=0x1000. ioctl_addr 0x3F → 0xFF; ioctl_addr 0x1040 → 0x00; prog_rd never asserted.
- Banking and SWAB: BA1_START=0x100000, SWAB=1. ioctl_rd @0x100003 → prog_ba=1, prog_addr=0x1; data 0x1234 → ioctl_din=0x12.
- Handshake corners:
  - ack and data_rdy in the same cycle with 0xBEEF → completes with 0xBE (even address, SWAB=0).
  - ack held off 5 cycles → prog_rd held for 5 cycles, ioctl_wait high throughout.
  - ioctl_rd mid-fetch → ignored.
- Abort: drop uploading in WAIT → prog_rd=0, ioctl_wait=0. A later data_rdy (0xFFFF) leaves ioctl_din unchanged. A new session rereads the same address from SDRAM (cache miss).
- Reset: assert rst in REQ → all outputs at their reset values on the next edge; the first read after reset is a miss.

Source files
------------

// File: rtl/jtframe_upld.sv
// jtframe_upld: streams SDRAM contents back out over the ioctl byte port.
// Byte requests become 16-bit SDRAM word reads; a one-word cache serves the
// second byte of a word without another SDRAM access. Address partitioning
// (header, banks, PROM region, byte swap) mirrors the download path.
module jtframe_upld #(
  parameter int unsigned HEADER     = 0,
  parameter logic [24:0] PROM_START = ~25'd0,
  parameter logic [24:0] BA1_START  = ~25'd0,
  parameter logic [24:0] BA2_START  = ~25'd0,
  parameter logic [24:0] BA3_START  = ~25'd0,
  parameter int unsigned SWAB       = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uploading,
  input  logic [24:0] ioctl_addr,
  input  logic        ioctl_rd,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic [21:0] prog_addr,
  output logic [1:0]  prog_ba,
  output logic        prog_rd,
  input  logic        sdram_ack,
  input  logic        data_rdy,
  input  logic [15:0] data_read
);

  localparam int unsigned AW = 25;
  localparam int unsigned WW = 22;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 8;

  localparam logic [AW-1:0] ALL_ONES = '1;
  localparam logic [AW-1:0] HDR_LEN  = AW'(HEADER);
  localparam logic          SWAB_B   = 1'(SWAB % 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t          r_state;
  logic [BW-1:0]   r_din;
  logic            r_wait;
  logic [WW-1:0]   r_prog_addr;
  logic [1:0]      r_prog_ba;
  logic            r_prog_rd;
  logic            r_sel;
  logic            r_valid;
  logic [DW-1:0]   r_cache;
  logic [WW-1:0]   r_tag_word;
  logic [1:0]      r_tag_ba;

  logic [AW-1:0]   w_part;
  logic            w_hdr;
  logic            w_prom;
  logic [1:0]      w_bank;
  logic [AW-1:0]   w_start;
  logic [AW-1:0]   w_eff;
  logic [WW-1:0]   w_word;
  logic            w_sel;
  logic            w_hit;
  logic [BW-1:0]   w_cache_byte;
  logic [BW-1:0]   w_rdy_byte;
  logic            w_done;
  logic            w_unused;

  // Address partitioning shared with the download side
  assign w_part = ioctl_addr - HDR_LEN;
  assign w_hdr  = (HDR_LEN != '0) && (ioctl_addr < HDR_LEN);
  assign w_prom = (PROM_START != ALL_ONES) && (w_part >= PROM_START);

  // Highest defined bank whose start is at or below the partition address
  always_comb begin
    w_bank  = 2'd0;
    w_start = '0;
    if (BA1_START != ALL_ONES && w_part >= BA1_START) begin
      w_bank  = 2'd1;
      w_start = BA1_START;
    end
    if (BA2_START != ALL_ONES && w_part >= BA2_START) begin
      w_bank  = 2'd2;
      w_start = BA2_START;
    end
    if (BA3_START != ALL_ONES && w_part >= BA3_START) begin
      w_bank  = 2'd3;
      w_start = BA3_START;
    end
  end

  assign w_eff    = w_part - w_start;
  assign w_word   = w_eff[WW:1];
  assign w_sel    = w_eff[0] ^ SWAB_B;
  assign w_unused = &{1'b0, w_eff[AW-1:WW+1]};

  // Cache lookup and byte-lane selection for both cached and fresh words
  assign w_hit        = r_valid && (r_tag_ba == w_bank) && (r_tag_word == w_word);
  assign w_cache_byte = w_sel ? r_cache[BW-1:0] : r_cache[DW-1:BW];
  assign w_rdy_byte   = r_sel ? data_read[BW-1:0] : data_read[DW-1:BW];

  // Fetch completes on data_rdy in WAIT, or together with the ack in REQ
  assign w_done = ((r_state == S_REQ) && sdram_ack && data_rdy) ||
                  ((r_state == S_WAIT) && data_rdy);

  // Upload FSM: request decode, SDRAM handshake and cache update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_din       <= '0;
      r_wait      <= 1'b0;
      r_prog_addr <= '0;
      r_prog_ba   <= '0;
      r_prog_rd   <= 1'b0;
      r_sel       <= 1'b0;
      r_valid     <= 1'b0;
      r_cache     <= '0;
      r_tag_word  <= '0;
      r_tag_ba    <= '0;
    end else if (!uploading) begin
      // No session: abort any fetch and keep the cache invalid so a new
      // session never sees a stale word
      r_state   <= S_IDLE;
      r_wait    <= 1'b0;
      r_prog_rd <= 1'b0;
      r_valid   <= 1'b0;
    end else if (w_done) begin
      r_cache    <= data_read;
      r_tag_word <= r_prog_addr;
      r_tag_ba   <= r_prog_ba;
      r_valid    <= 1'b1;
      r_din      <= w_rdy_byte;
      r_wait     <= 1'b0;
      r_prog_rd  <= 1'b0;
      r_state    <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ioctl_rd) begin
            if (w_hdr) begin
              r_din <= 8'hFF;
            end else if (w_prom) begin
              r_din <= 8'h00;
            end else if (w_hit) begin
              r_din <= w_cache_byte;
            end else begin
              r_wait      <= 1'b1;
              r_prog_rd   <= 1'b1;
              r_prog_addr <= w_word;
              r_prog_ba   <= w_bank;
              r_sel       <= w_sel;
              r_state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (sdram_ack) begin
            r_prog_rd <= 1'b0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_state <= S_WAIT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ioctl_din  = r_din;
  assign ioctl_wait = r_wait;
  assign prog_addr  = r_prog_addr;
  assign prog_ba    = r_prog_ba;
  assign prog_rd    = r_prog_rd;

endmodule
